// File: rtl/pendulum_pkg.sv
// Shared types and constants for the pendulum balance loop sequencer.
package pendulum_pkg;

    localparam int ANGLE_W     = 8;
    localparam int DUTY_W      = 8;
    localparam int U_MAX       = 255;
    localparam int REQ_TIMEOUT = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CALC,
        UPDATE,
        FAULT
    } state_t;

endpackage

// File: rtl/pendulum_pwm_gen.sv
// 255-step PWM generator; duty and direction are reloaded only at the period wrap
// so a new control value never produces a truncated or stretched pulse.
module pendulum_pwm_gen
    import pendulum_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] pending_duty_i,
    input  logic              pending_dir_i,
    output logic              pwm_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              dir_o
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(U_MAX - 1);

    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic              wrap;

    always_comb begin
        wrap   = (cnt_q == CNT_LAST);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        duty_d = wrap ? pending_duty_i : duty_q;
        dir_d  = wrap ? pending_dir_i : dir_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            duty_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            dir_q  <= dir_d;
        end
    end

    // Counter tops out at 254, so duty 255 is a constant high and duty 0 a constant low.
    assign pwm_o  = (cnt_q < duty_q);
    assign duty_o = duty_q;
    assign dir_o  = dir_q;

endmodule

// File: rtl/pendulum_loop_sequencer.sv
// Sampled PD control loop for an inverted pendulum cart: request angle, compute effort, drive PWM.
// Define PEND_FAULT_EN to build in the over-angle fault monitor.
module pendulum_loop_sequencer
    import pendulum_pkg::*;
#(
    parameter int SAMPLE_DIV  = 100,
    parameter int KP          = 4,
    parameter int KD          = 8,
    parameter int FAULT_LIMIT = 60,
    parameter int FAULT_COUNT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic signed [ANGLE_W-1:0] pendulum_angle_sensor,
    input  logic                      sensor_ack,
    input  logic                      fault_clear,
    output logic                      sensor_req,
    output logic                      cart_motor_control,
    output logic                      motor_dir,
    output logic [DUTY_W-1:0]         duty,
    output logic                      fault
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int TO_W   = $clog2(REQ_TIMEOUT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(REQ_TIMEOUT - 1);
    localparam logic signed [15:0] KP_S = 16'(KP);
    localparam logic signed [15:0] KD_S = 16'(KD);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [ANGLE_W-1:0]  angle_q, angle_d;
    logic [ANGLE_W-1:0]  prev_q, prev_d;
    logic [DUTY_W-1:0]   u_mag_q, u_mag_d;
    logic                u_neg_q, u_neg_d;
    logic [DUTY_W-1:0]   pend_duty_q, pend_duty_d;
    logic                pend_dir_q, pend_dir_d;
    logic                tick;

    logic signed [15:0]  angle_x, prev_x, d_x, u_full;
    logic [15:0]         u_abs;
    logic [DUTY_W-1:0]   u_sat;

`ifdef PEND_FAULT_EN
    localparam int OVER_W = $clog2(FAULT_COUNT + 1);
    localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(FAULT_COUNT - 1);
    logic [OVER_W-1:0]   over_q, over_d;
    logic [15:0]         ang_abs;
    logic                over_limit;
`endif

    // PD law in 16-bit signed: worst case 15*128 + 15*255*2 stays far inside range.
    always_comb begin
        angle_x = {{(16-ANGLE_W){angle_q[ANGLE_W-1]}}, angle_q};
        prev_x  = {{(16-ANGLE_W){prev_q[ANGLE_W-1]}}, prev_q};
        d_x     = angle_x - prev_x;
        u_full  = KP_S * angle_x + KD_S * d_x;
        u_abs   = u_full[15] ? -u_full : u_full;
        u_sat   = (u_abs > 16'(U_MAX)) ? DUTY_W'(U_MAX) : u_abs[DUTY_W-1:0];
`ifdef PEND_FAULT_EN
        ang_abs    = angle_x[15] ? -angle_x : angle_x;
        over_limit = (ang_abs > 16'(FAULT_LIMIT));
`endif
    end

    assign tick = enable && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        prev_d      = prev_q;
        u_mag_d     = u_mag_q;
        u_neg_d     = u_neg_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
`ifdef PEND_FAULT_EN
        over_d      = over_q;
`endif
        tick_cnt_d  = (!enable || tick) ? '0 : tick_cnt_q + 1'b1;
        to_d        = (state_q == REQ) ? to_q + 1'b1 : '0;

        case (state_q)
            IDLE: if (tick) state_d = REQ;
            REQ: begin
                if (sensor_ack) begin
                    state_d = CALC;
                    angle_d = pendulum_angle_sensor;
                end else if (to_q == TO_LAST) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                state_d = UPDATE;
                u_mag_d = u_sat;
                u_neg_d = u_full[15];
                prev_d  = angle_q;
`ifdef PEND_FAULT_EN
                over_d = over_limit ? over_q + 1'b1 : '0;
                if (over_limit && over_q == OVER_LAST) state_d = FAULT;
`endif
            end
            UPDATE: begin
                state_d     = IDLE;
                pend_duty_d = u_mag_q;
                pend_dir_d  = u_neg_q;
            end
`ifdef PEND_FAULT_EN
            FAULT: begin
                if (fault_clear) begin
                    state_d = IDLE;
                    prev_d  = '0;
                    over_d  = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Disabled or faulted loop must not leave a stale drive queued for the PWM.
        if (!enable || state_q == FAULT) begin
            pend_duty_d = '0;
            pend_dir_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            to_q        <= '0;
            angle_q     <= '0;
            prev_q      <= '0;
            u_mag_q     <= '0;
            u_neg_q     <= 1'b0;
            pend_duty_q <= '0;
            pend_dir_q  <= 1'b0;
`ifdef PEND_FAULT_EN
            over_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            to_q        <= to_d;
            angle_q     <= angle_d;
            prev_q      <= prev_d;
            u_mag_q     <= u_mag_d;
            u_neg_q     <= u_neg_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
`ifdef PEND_FAULT_EN
            over_q      <= over_d;
`endif
        end
    end

    assign sensor_req = (state_q == REQ);

`ifdef PEND_FAULT_EN
    assign fault = (state_q == FAULT);
`else
    logic [16:0] unused_fault_cfg;
    assign unused_fault_cfg = {fault_clear, 16'(FAULT_LIMIT + FAULT_COUNT)};
    assign fault = 1'b0;
`endif

    pendulum_pwm_gen u_pwm (
        .clk            (clk),
        .reset          (reset),
        .pending_duty_i (pend_duty_q),
        .pending_dir_i  (pend_dir_q),
        .pwm_o          (cart_motor_control),
        .duty_o         (duty),
        .dir_o          (motor_dir)
    );

endmodule

// File: tb/tb_pendulum_loop_sequencer.sv
// Directed bench for pendulum_loop_sequencer: table of PD samples plus timeout, enable, reset and fault sequences.
module tb_pendulum_loop_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] angle;
    logic       sensor_ack;
    logic       fault_clear;
    logic       sensor_req;
    logic       cart_motor_control;
    logic       motor_dir;
    logic [7:0] duty;
    logic       fault;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    pendulum_loop_sequencer #(
        .SAMPLE_DIV  (100),
        .KP          (4),
        .KD          (8),
        .FAULT_LIMIT (60),
        .FAULT_COUNT (3)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .pendulum_angle_sensor (angle),
        .sensor_ack            (sensor_ack),
        .fault_clear           (fault_clear),
        .sensor_req            (sensor_req),
        .cart_motor_control    (cart_motor_control),
        .motor_dir             (motor_dir),
        .duty                  (duty),
        .fault                 (fault)
    );

    typedef struct {
        logic [7:0] angle;
        int         ack_dly;
        int         exp_duty;
        int         exp_dir;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for a fresh sample request; a stray ack is driven while no request is open.
    task automatic wait_req(output int ok);
        int n;
        n = 0;
        while (sensor_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        sensor_ack = 1'b1;
        angle      = 8'h7F;
        @(negedge clk);
        sensor_ack = 1'b0;
        angle      = 8'h00;
        n = 0;
        while (!sensor_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = sensor_req ? 1 : 0;
    endtask

    task automatic do_sample(input logic [7:0] a, input int dly, input string name);
        int ok;
        wait_req(ok);
        check({name, "_req_seen"}, ok, 1);
        if (ok == 1) begin
            repeat (dly) @(negedge clk);
            angle      = a;
            sensor_ack = 1'b1;
            @(negedge clk);
            sensor_ack = 1'b0;
            angle      = 8'h00;
            check({name, "_req_drop"}, int'(sensor_req), 0);
        end
    endtask

    // Lets the result reach the PWM, then checks duty, direction and high time over one full period.
    task automatic settle_check(input int exp_duty, input int exp_dir, input string name);
        int high;
        repeat (300) @(negedge clk);
        check({name, "_duty"}, int'(duty), exp_duty);
        check({name, "_dir"}, int'(motor_dir), exp_dir);
        high = 0;
        for (int k = 0; k < 255; k++) begin
            if (cart_motor_control) high++;
            @(negedge clk);
        end
        check({name, "_high"}, high, exp_duty);
        $display("sample %s: duty=%0d dir=%0d high=%0d (want %0d/%0d)",
                 name, duty, motor_dir, high, exp_duty, exp_dir);
    endtask

    initial begin
        int ok;
        int n;
        int req_hi;

        vecs[0]  = '{8'd0,        2, 0,   0};
        vecs[1]  = '{8'd1,        2, 12,  0};
        vecs[2]  = '{8'd2,        1, 16,  0};
        vecs[3]  = '{8'hFF,       0, 28,  1};
        vecs[4]  = '{8'd5,        3, 68,  0};
        vecs[5]  = '{8'd100,      2, 255, 0};
        vecs[6]  = '{8'(-100),    1, 255, 1};
        vecs[7]  = '{8'(-50),     4, 200, 0};
        vecs[8]  = '{8'(-20),     0, 160, 0};
        vecs[9]  = '{8'(-20),     2, 80,  1};
        vecs[10] = '{8'd10,       5, 255, 0};
        vecs[11] = '{8'd10,       1, 40,  0};
        vecs[12] = '{8'd127,      2, 255, 0};
        vecs[13] = '{8'h80,       3, 255, 1};
        vecs[14] = '{8'(-60),     0, 255, 0};
        vecs[15] = '{8'(-60),     7, 240, 1};

        reset       = 1'b0;
        enable      = 1'b0;
        angle       = 8'h00;
        sensor_ack  = 1'b0;
        fault_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req",   int'(sensor_req), 0);
        check("rst_pwm",   int'(cart_motor_control), 0);
        check("rst_dir",   int'(motor_dir), 0);
        check("rst_duty",  int'(duty), 0);
        check("rst_fault", int'(fault), 0);

        reset  = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_sample(vecs[i].angle, vecs[i].ack_dly, $sformatf("vec%0d", i));
            settle_check(vecs[i].exp_duty, vecs[i].exp_dir, $sformatf("vec%0d", i));
        end

        // Unanswered request: 16 cycles of sensor_req, nothing changes.
        wait_req(ok);
        check("to_req_seen", ok, 1);
        n = 0;
        while (sensor_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_req_len", n, 16);
        settle_check(240, 1, "timeout_hold");
        // prev_angle must still be -60: d=70 saturates, whereas a cleared prev would give 120.
        do_sample(8'd10, 1, "after_to");
        settle_check(255, 0, "after_to");

        // Loop disabled: no requests, drive decays to zero.
        enable = 1'b0;
        repeat (20) @(negedge clk);
        req_hi = 0;
        for (int k = 0; k < 300; k++) begin
            if (sensor_req) req_hi++;
            @(negedge clk);
        end
        check("dis_no_req", req_hi, 0);
        settle_check(0, 0, "disabled");
        enable = 1'b1;

        do_sample(8'd0, 2, "re_en0");
        settle_check(80, 1, "re_en0");
        do_sample(8'd2, 0, "re_en2");
        settle_check(24, 0, "re_en2");
        do_sample(8'd18, 3, "duty200");
        settle_check(200, 0, "duty200");

        // Reset in the middle of a request.
        wait_req(ok);
        check("mid_req_seen", ok, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_req",  int'(sensor_req), 0);
        check("mid_rst_pwm",  int'(cart_motor_control), 0);
        check("mid_rst_duty", int'(duty), 0);
        check("mid_rst_dir",  int'(motor_dir), 0);
        @(negedge clk);
        reset = 1'b1;
        do_sample(8'd2, 2, "post_rst");
        settle_check(24, 0, "post_rst");

        // Three over-limit samples in a row.
        do_sample(8'd70, 1, "over1");
        settle_check(255, 0, "over1");
        do_sample(8'd70, 1, "over2");
        settle_check(255, 0, "over2");
        do_sample(8'd70, 1, "over3");
`ifdef PEND_FAULT_EN
        check("fault_set", int'(fault), 1);
        settle_check(0, 0, "faulted");
        req_hi = 0;
        for (int k = 0; k < 300; k++) begin
            if (sensor_req) req_hi++;
            @(negedge clk);
        end
        check("fault_no_req", req_hi, 0);
        check("fault_sticky", int'(fault), 1);
`else
        check("no_fault", int'(fault), 0);
        settle_check(255, 0, "over3");
`endif
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        check("fault_cleared", int'(fault), 0);
        do_sample(8'd1, 2, "after_clr");
`ifdef PEND_FAULT_EN
        settle_check(12, 0, "after_clr");
`else
        settle_check(255, 1, "after_clr");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
